// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Divide by zero completes in a single cycle with all result bits forced high.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] part, part_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] divisor, divisor_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic             err_nxt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             accept;

  // The partial remainder is always below the divisor, so its top bit of the
  // WIDTH+1-bit arithmetic form is constantly zero and is not stored.
  assign shifted = {part, shreg[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign accept  = start && (state != CALC);

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      part      <= '0;
      shreg     <= '0;
      divisor   <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      part      <= part_nxt;
      shreg     <= shreg_nxt;
      divisor   <= divisor_nxt;
      count     <= count_nxt;
      quotient  <= quo_nxt;
      remainder <= rem_nxt;
      error     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    part_nxt    = part;
    shreg_nxt   = shreg;
    divisor_nxt = divisor;
    count_nxt   = count;
    quo_nxt     = quotient;
    rem_nxt     = remainder;
    err_nxt     = error;

    case (state)
      IDLE, DONE: begin
        if (accept) begin
          divisor_nxt = B;
          shreg_nxt   = A;
          count_nxt   = CW'(WIDTH);
          err_nxt     = 1'b0;
          if (B == '0) begin
            quo_nxt   = '1;
            rem_nxt   = '1;
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            part_nxt  = '0;
            state_nxt = CALC;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      CALC: begin
        if (trial[WIDTH]) begin
          part_nxt  = shifted[WIDTH-1:0];
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        end else begin
          part_nxt  = trial[WIDTH-1:0];
          shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
        end
        count_nxt = count - CW'(1);
        if (count == CW'(1)) begin
          quo_nxt   = shreg_nxt;
          rem_nxt   = part_nxt;
          state_nxt = DONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus scoreboard queue,
// with hand-written sequences for busy-ignore, back-to-back and async reset.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [7:0] quotient, remainder;
  logic       busy, done, error;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        e;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("busy_done_exclusive", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", {24'd0, quotient}, {24'd0, mon_e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, mon_e.r});
        chk("error", {31'd0, error}, {31'd0, mon_e.e});
        chk("done_latency", cyc, mon_e.due);
      end
    end
  end

  // Called at a negedge; edge k is the next posedge.
  task automatic do_start(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic ee, input bit push);
    exp_t e;
    A = a;
    B = b;
    start = 1'b1;
    e.q = eq; e.r = er; e.e = ee;
    e.due = cyc + 1 + ((b == 8'd0) ? 0 : 8);
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  initial begin
    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[4] = '{8'd100, 8'd0,   8'hFF,  8'hFF,  1'b1};
    vecs[5] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
    vecs[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[7] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
    vecs[8] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
    vecs[9] = '{8'd254, 8'd13,  8'd19,  8'd7,   1'b0};

    #1 rst = 1'b1;
    #1;
    chk("reset_quotient", {24'd0, quotient}, 32'd0);
    chk("reset_remainder", {24'd0, remainder}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_error", {31'd0, error}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_start(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e, 1);
      chk("busy_after_start", {31'd0, busy}, {31'd0, (vecs[i].b != 8'd0)});
      wait_done();
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("hold_quotient", {24'd0, quotient}, {24'd0, vecs[i].q});
      chk("hold_remainder", {24'd0, remainder}, {24'd0, vecs[i].r});
      chk("hold_error", {31'd0, error}, {31'd0, vecs[i].e});
    end

    // Start pulses and operand changes while busy must be ignored.
    do_start(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1);
    A = 8'd10;
    B = 8'd2;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      A = 8'($urandom);
      B = 8'($urandom);
    end
    start = 1'b0;
    wait_done();

    // Start accepted in the same cycle done is high.
    do_start(8'd64, 8'd8, 8'd8, 8'd0, 1'b0, 1);
    chk("b2b_done_dropped", {31'd0, done}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done();
    @(negedge clk);

    // Asynchronous reset mid-calculation discards the division.
    do_start(8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_quotient", {24'd0, quotient}, 32'd0);
    chk("async_rst_remainder", {24'd0, remainder}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    do_start(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1);
    wait_done();
    repeat (2) @(negedge clk);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
